// File: rtl/mipi_csi_raw_depacker.sv
`default_nettype none
// ============================================================================
// Module   : mipi_csi_raw_depacker
// Purpose  : Unpacks 4-lane CSI-2 RAW10/12/14 byte streams into 4 pixels
// Revision : 1.0 - initial release
// ============================================================================
module mipi_csi_raw_depacker (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  packet_type_i,
    output logic        output_valid_o,
    output logic [63:0] output_o
);

    localparam logic [2:0] C_TYPE_RAW10 = 3'd3;
    localparam logic [2:0] C_TYPE_RAW12 = 3'd4;
    localparam logic [2:0] C_TYPE_RAW14 = 3'd5;

    logic [79:0] r_buf;
    logic [3:0]  r_count;
    logic [2:0]  r_type;
    logic        r_prev_idle;
    logic        r_in_burst;

    logic        w_burst_start;
    logic        w_active;
    logic [2:0]  w_type;
    logic [3:0]  w_n;
    logic        w_supported;
    logic [3:0]  w_sum;
    logic        w_extract;
    logic [79:0] w_merged;
    logic [79:0] w_remain;
    logic [7:0]  w_b [7];
    logic [63:0] w_pixels;

    // A burst only starts after an observed idle cycle, so a burst that was
    // already running across reset is ignored until the stream goes idle.
    assign w_burst_start = data_valid_i & r_prev_idle;
    assign w_active      = data_valid_i & (w_burst_start | r_in_burst);
    assign w_type        = w_burst_start ? packet_type_i : r_type;

    always_comb begin
        w_n         = 4'd0;
        w_supported = 1'b0;
        case (w_type)
            C_TYPE_RAW10: begin w_n = 4'd5; w_supported = 1'b1; end
            C_TYPE_RAW12: begin w_n = 4'd6; w_supported = 1'b1; end
            C_TYPE_RAW14: begin w_n = 4'd7; w_supported = 1'b1; end
            default:      begin w_n = 4'd0; w_supported = 1'b0; end
        endcase
    end

    assign w_sum     = r_count + 4'd4;
    assign w_extract = w_active & w_supported & (w_sum >= w_n);
    assign w_merged  = r_buf | ({48'h0, data_i} << {r_count, 3'b000});
    assign w_remain  = w_merged >> {w_n, 3'b000};

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            w_b[i] = w_merged[8*i +: 8];
        end
    end

    always_comb begin
        w_pixels = 64'h0;
        case (w_type)
            C_TYPE_RAW10: w_pixels = {6'd0, w_b[3], w_b[4][7:6],
                                      6'd0, w_b[2], w_b[4][5:4],
                                      6'd0, w_b[1], w_b[4][3:2],
                                      6'd0, w_b[0], w_b[4][1:0]};
            C_TYPE_RAW12: w_pixels = {4'd0, w_b[4], w_b[5][7:4],
                                      4'd0, w_b[3], w_b[5][3:0],
                                      4'd0, w_b[1], w_b[2][7:4],
                                      4'd0, w_b[0], w_b[2][3:0]};
            C_TYPE_RAW14: w_pixels = {2'd0, w_b[3], w_b[6][7:2],
                                      2'd0, w_b[2], w_b[6][1:0], w_b[5][7:4],
                                      2'd0, w_b[1], w_b[5][3:0], w_b[4][7:6],
                                      2'd0, w_b[0], w_b[4][5:0]};
            default:      w_pixels = 64'h0;
        endcase
    end

    always_ff @(negedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_buf          <= 80'h0;
            r_count        <= 4'd0;
            r_type         <= 3'd0;
            r_prev_idle    <= 1'b0;
            r_in_burst     <= 1'b0;
            output_valid_o <= 1'b0;
            output_o       <= 64'h0;
        end else begin
            r_prev_idle    <= ~data_valid_i;
            r_in_burst     <= w_active;
            output_valid_o <= w_extract;
            if (w_burst_start) begin
                r_type <= packet_type_i;
            end
            if (w_extract) begin
                output_o <= w_pixels;
            end
            if (w_active && w_supported) begin
                if (w_extract) begin
                    r_buf   <= w_remain;
                    r_count <= w_sum - w_n;
                end else begin
                    r_buf   <= w_merged;
                    r_count <= w_sum;
                end
            end else begin
                r_buf   <= 80'h0;
                r_count <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_raw_depacker.sv
`default_nettype none
// Directed testbench for mipi_csi_raw_depacker.
module tb_mipi_csi_raw_depacker;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic [2:0]  packet_type_i = 3'd0;
    logic        output_valid_o;
    logic [63:0] output_o;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    logic [63:0] held;

    mipi_csi_raw_depacker dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .packet_type_i  (packet_type_i),
        .output_valid_o (output_valid_o),
        .output_o       (output_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change at the rising edge; DUT captures at the falling edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] t);
        @(posedge clk_i);
        data_valid_i  = v;
        data_i        = d;
        packet_type_i = t;
        @(negedge clk_i);
        #1;
        if (output_valid_o === 1'b1) pulses++;
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if (output_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", output_valid_o); end
        n_checks++;
        if (output_o !== 64'h0) begin n_errors++; $display("FAIL reset_out: got %h expected 0", output_o); end
        n_checks++;
        if (dut.r_count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", dut.r_count); end
        @(posedge clk_i);
        reset_n_i = 1'b1;
        drive(1'b0, 32'h0, 3'd0);
    endtask

    task automatic test_raw10;
        drive(1'b0, 32'h0, 3'd0);
        drive(1'b1, 32'h44332211, 3'd3);
        n_checks++;
        if (output_valid_o !== 1'b0) begin n_errors++; $display("FAIL raw10_early_valid: got %b expected 0", output_valid_o); end
        drive(1'b1, 32'h000000E4, 3'd3);
        n_checks++;
        if (output_valid_o !== 1'b1) begin n_errors++; $display("FAIL raw10_valid: got %b expected 1", output_valid_o); end
        n_checks++;
        if (output_o !== 64'h0113_00CE_0089_0044) begin n_errors++; $display("FAIL raw10_out: got %h expected 0113_00ce_0089_0044", output_o); end
        n_checks++;
        if (dut.r_count !== 4'd3) begin n_errors++; $display("FAIL raw10_count: got %0d expected 3", dut.r_count); end
        drive(1'b0, 32'hFFFFFFFF, 3'd3);
        n_checks++;
        if (output_valid_o !== 1'b0) begin n_errors++; $display("FAIL raw10_pulse_width: got %b expected 0", output_valid_o); end
        n_checks++;
        if (output_o !== 64'h0113_00CE_0089_0044) begin n_errors++; $display("FAIL raw10_hold: got %h expected 0113_00ce_0089_0044", output_o); end
        n_checks++;
        if (dut.r_count !== 4'd0) begin n_errors++; $display("FAIL raw10_idle_count: got %0d expected 0", dut.r_count); end
    endtask

    task automatic test_raw12;
        drive(1'b0, 32'h0, 3'd0);
        pulses = 0;
        drive(1'b1, 32'h1221CDAB, 3'd4);
        drive(1'b1, 32'h00006534, 3'd4);
        n_checks++;
        if (output_o !== 64'h0346_0125_0CD2_0AB1) begin n_errors++; $display("FAIL raw12_out: got %h expected 0346_0125_0cd2_0ab1", output_o); end
        n_checks++;
        if (dut.r_count !== 4'd2) begin n_errors++; $display("FAIL raw12_count: got %0d expected 2", dut.r_count); end
        drive(1'b0, 32'h0, 3'd0);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL raw12_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_raw14;
        drive(1'b0, 32'h0, 3'd0);
        drive(1'b1, 32'h04030201, 3'd5);
        drive(1'b1, 32'h005BA6C5, 3'd5);
        n_checks++;
        if (output_o !== 64'h0116_00FA_009B_0045) begin n_errors++; $display("FAIL raw14_out: got %h expected 0116_00fa_009b_0045", output_o); end
        n_checks++;
        if (dut.r_count !== 4'd1) begin n_errors++; $display("FAIL raw14_count: got %0d expected 1", dut.r_count); end
    endtask

    task automatic test_type_latch;
        drive(1'b0, 32'h0, 3'd0);
        drive(1'b1, 32'h44332211, 3'd3);
        drive(1'b1, 32'h000000E4, 3'd4);
        n_checks++;
        if (output_o !== 64'h0113_00CE_0089_0044) begin n_errors++; $display("FAIL type_latch_out: got %h expected 0113_00ce_0089_0044", output_o); end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 32'h0, 3'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h11111111 * (i + 1), 3'd3);
        n_checks++;
        if (pulses !== 4) begin n_errors++; $display("FAIL b2b_raw10_pulses: got %0d expected 4", pulses); end
        n_checks++;
        if (dut.r_count !== 4'd0) begin n_errors++; $display("FAIL b2b_raw10_count: got %0d expected 0", dut.r_count); end
        drive(1'b0, 32'h0, 3'd0);
        pulses = 0;
        for (int i = 0; i < 7; i++) drive(1'b1, 32'hA5A55A5A ^ i, 3'd5);
        n_checks++;
        if (pulses !== 4) begin n_errors++; $display("FAIL b2b_raw14_pulses: got %0d expected 4", pulses); end
        n_checks++;
        if (dut.r_count !== 4'd0) begin n_errors++; $display("FAIL b2b_raw14_count: got %0d expected 0", dut.r_count); end
    endtask

    task automatic test_truncated;
        drive(1'b0, 32'h0, 3'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h01020304 + i, 3'd5);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL trunc_pulses: got %0d expected 1", pulses); end
        n_checks++;
        if (dut.r_count !== 4'd5) begin n_errors++; $display("FAIL trunc_residual: got %0d expected 5", dut.r_count); end
        held = output_o;
        drive(1'b0, 32'h0, 3'd5);
        n_checks++;
        if (dut.r_count !== 4'd0) begin n_errors++; $display("FAIL trunc_discard: got %0d expected 0", dut.r_count); end
        n_checks++;
        if (output_valid_o !== 1'b0) begin n_errors++; $display("FAIL trunc_no_partial: got %b expected 0", output_valid_o); end
        drive(1'b1, 32'hDEADBEEF, 3'd4);
        n_checks++;
        if (dut.r_count !== 4'd4) begin n_errors++; $display("FAIL trunc_clean_start: got %0d expected 4", dut.r_count); end
        drive(1'b0, 32'h0, 3'd0);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL trunc_dropped_group: got %0d expected 1", pulses); end
    endtask

    task automatic test_async_reset;
        drive(1'b0, 32'h0, 3'd0);
        drive(1'b1, 32'h44332211, 3'd3);
        drive(1'b1, 32'h000000E4, 3'd3);
        @(posedge clk_i);
        data_i = 32'h55667788;
        #2;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (output_o !== 64'h0) begin n_errors++; $display("FAIL async_rst_out: got %h expected 0", output_o); end
        n_checks++;
        if (output_valid_o !== 1'b0) begin n_errors++; $display("FAIL async_rst_valid: got %b expected 0", output_valid_o); end
        @(negedge clk_i);
        @(posedge clk_i);
        reset_n_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h12345678, 3'd3);
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL async_rst_stale_burst: got %0d expected 0", pulses); end
        drive(1'b0, 32'h0, 3'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h89ABCDEF, 3'd6);
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL unsupported_pulses: got %0d expected 0", pulses); end
        n_checks++;
        if (dut.r_count !== 4'd0) begin n_errors++; $display("FAIL unsupported_count: got %0d expected 0", dut.r_count); end
        drive(1'b0, 32'h0, 3'd0);
        drive(1'b1, 32'h44332211, 3'd3);
        drive(1'b1, 32'h000000E4, 3'd3);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL recover_pulses: got %0d expected 1", pulses); end
        drive(1'b0, 32'h0, 3'd0);
    endtask

    initial begin
        test_reset();
        test_raw10();
        test_raw12();
        test_raw14();
        test_type_latch();
        test_back_to_back();
        test_truncated();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mipi_csi_raw_depacker.md
MIPI_CSI_RAW_DEPACKER -- requirements
Module: mipi_csi_raw_depacker

Interface
REQ-001 SHALL have parameters: none; lane count fixed at 4, so 4 payload bytes arrive per valid cycle.
REQ-002 SHALL have port clk_i, input, 1 bit: MIPI byte clock; all registers update on the falling edge.
REQ-003 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port data_valid_i, input, 1 bit: payload valid from the packet decoder.
REQ-005 SHALL have port data_i, input, 32 bits: stripped payload; [7:0] is the earliest byte (B0), [31:24] the latest.
REQ-006 SHALL have port packet_type_i, input, 3 bits: 3'd3 = RAW10, 3'd4 = RAW12, 3'd5 = RAW14; any other value is unsupported.
REQ-007 SHALL have port output_valid_o, output, 1 bit: output_o holds 4 valid pixels.
REQ-008 SHALL have port output_o, output, 64 bits: pixel k occupies [16k+15:16k], right-aligned and zero-extended; pixel 0 is the earliest.

Function
REQ-009 SHALL hold an 80-bit byte buffer plus a 4-bit byte count (0..10); new bytes append above the current count.
REQ-010 SHALL latch packet_type_i into a type register on the first data_valid_i=1 cycle after a data_valid_i=0 cycle (burst start), and ignore packet_type_i for the rest of the burst.
REQ-011 SHALL use a group size N of 5 for RAW10, 6 for RAW12 and 7 for RAW14.
REQ-012 SHALL, on each valid cycle with a supported type, append 4 bytes; if count+4 >= N, extract the lowest N bytes as one group, shift the rest down, and set count = count+4-N; otherwise set count = count+4.
REQ-013 SHALL extract at most one group per cycle; since N > 4, count stays <= N-1 after every cycle, so the buffer never overflows.
REQ-014 SHALL depack RAW10 as pixel k = {Bk, B4[2k+1:2k]} for k = 0..3.
REQ-015 SHALL depack RAW12 as P0={B0,B2[3:0]}, P1={B1,B2[7:4]}, P2={B3,B5[3:0]}, P3={B4,B5[7:4]}.
REQ-016 SHALL depack RAW14 as P0={B0,B4[5:0]}, P1={B1,B5[3:0],B4[7:6]}, P2={B2,B6[1:0],B5[7:4]}, P3={B3,B6[7:2]}.
REQ-017 SHALL register output_o and output_valid_o, so pixels appear one clock after the input word that completes the group.
REQ-018 SHALL pulse output_valid_o high for exactly one cycle per extracted group, and drive it low in every other cycle.
REQ-019 SHALL hold output_o at its last value while output_valid_o=0.
REQ-020 SHALL, when data_valid_i=0, clear count to 0, discard residual bytes (fewer than N), and drive output_valid_o=0 on the next edge.
REQ-021 SHALL, on an unsupported latched type, never assert output_valid_o for that burst and keep count at 0.
REQ-022 SHALL, if data_valid_i falls in the same cycle that a group would complete, not extract that group, because the word is not valid.
REQ-023 SHALL produce exactly 4*floor(bytes/N) pixels per burst, where bytes = 4 × the number of valid cycles.

Reset
REQ-024 SHALL, while reset_n_i=0, force output_valid_o=0, output_o=64'h0, count=0, buffer=0 and type register=0, regardless of clk_i.
REQ-025 SHALL require a new burst start after reset release, so a burst already in progress when reset asserts is fully discarded.

Verification
REQ-026 RAW10 type=3, data_i=0x44332211 then 0x000000E4 -> one edge after the second word: output_valid_o=1, output_o=0x0113_00CE_0089_0044; count=3.
REQ-027 RAW12 type=4, data_i=0x1221CDAB then 0x00006534 -> output_o=0x0346_0125_0CD2_0AB1, single valid pulse; count=2.
REQ-028 RAW10 burst of 5 words then RAW14 burst of 7 words -> exactly 4 valid pulses each (16 pixels); count=0 at end of each burst.
REQ-029 RAW14, data_valid_i dropped after 3 words (12 bytes) -> 1 pulse; 5 residual bytes discarded; the next burst starts clean with count=0.
REQ-030 reset_n_i pulsed low mid-burst (asynchronously, between edges) -> outputs zero immediately; type=6 burst -> no pulses at all.
